// File: rtl/wb_arbiter2.sv
// -----------------------------------------------------------------------------
// wb_arbiter2
// Two-master, one-slave Wishbone-style arbiter with round-robin grant and a
// per-transfer ack timeout.
//
// The grant (IDLE / OWN0 / OWN1) is registered. While a master owns the slave,
// its cycle, strobe, write enable, width, address and write data reach the
// slave combinationally, and the slave's stall and ack come straight back.
// This lets a zero-latency slave complete one transfer per clock.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_mN_cyc / stb / we             master N cycle, strobe, write enable
//   i_mN_width                      master N size: 00 byte, 01 half, 1x word
//   i_mN_addr, i_mN_data            master N byte address and write data
//   o_mN_stl / ack / err            stall, ack and timeout-error pulse to N
//   o_mN_data                       read data to master N (valid with ack)
//   o_s_cyc / stb / we / width      shared-slave control
//   o_s_addr, o_s_data              shared-slave address and write data
//   i_s_stl, i_s_ack, i_s_data      shared-slave stall, ack and read data
// -----------------------------------------------------------------------------
module wb_arbiter2 #(
    parameter int ADDR_WIDTH = 6,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_m0_cyc,
    input  logic                  i_m1_cyc,
    input  logic                  i_m0_stb,
    input  logic                  i_m1_stb,
    input  logic                  i_m0_we,
    input  logic                  i_m1_we,
    input  logic [1:0]            i_m0_width,
    input  logic [1:0]            i_m1_width,
    input  logic [ADDR_WIDTH-1:0] i_m0_addr,
    input  logic [ADDR_WIDTH-1:0] i_m1_addr,
    input  logic [31:0]           i_m0_data,
    input  logic [31:0]           i_m1_data,
    output logic                  o_m0_stl,
    output logic                  o_m1_stl,
    output logic                  o_m0_ack,
    output logic                  o_m1_ack,
    output logic                  o_m0_err,
    output logic                  o_m1_err,
    output logic [31:0]           o_m0_data,
    output logic [31:0]           o_m1_data,
    output logic                  o_s_cyc,
    output logic                  o_s_stb,
    output logic                  o_s_we,
    output logic [1:0]            o_s_width,
    output logic [ADDR_WIDTH-1:0] o_s_addr,
    output logic [31:0]           o_s_data,
    input  logic                  i_s_stl,
    input  logic                  i_s_ack,
    input  logic [31:0]           i_s_data
);

    localparam int              TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state_r;
    logic            last_r;    // 1: m1 served last, so m0 wins the next tie
    logic [TO_W-1:0] cnt_r;     // wait cycles of the current strobe

    logic                  own_cyc_s;
    logic                  own_stb_s;
    logic                  own_we_s;
    logic [1:0]            own_width_s;
    logic [ADDR_WIDTH-1:0] own_addr_s;
    logic [31:0]           own_data_s;
    logic                  timeout_s;

    // Select the current owner's bus signals; nothing is forwarded in IDLE.
    always_comb begin
        own_cyc_s   = 1'b0;
        own_stb_s   = 1'b0;
        own_we_s    = 1'b0;
        own_width_s = 2'b00;
        own_addr_s  = {ADDR_WIDTH{1'b0}};
        own_data_s  = 32'h0000_0000;
        case (state_r)
            OWN0: begin
                own_cyc_s   = i_m0_cyc;
                own_stb_s   = i_m0_stb;
                own_we_s    = i_m0_we;
                own_width_s = i_m0_width;
                own_addr_s  = i_m0_addr;
                own_data_s  = i_m0_data;
            end
            OWN1: begin
                own_cyc_s   = i_m1_cyc;
                own_stb_s   = i_m1_stb;
                own_we_s    = i_m1_we;
                own_width_s = i_m1_width;
                own_addr_s  = i_m1_addr;
                own_data_s  = i_m1_data;
            end
            default: begin
                own_cyc_s   = 1'b0;
                own_stb_s   = 1'b0;
                own_we_s    = 1'b0;
                own_width_s = 2'b00;
                own_addr_s  = {ADDR_WIDTH{1'b0}};
                own_data_s  = 32'h0000_0000;
            end
        endcase
    end

    // An ack in the cycle the counter hits its limit beats the timeout.
    always_comb begin
        if ((state_r == OWN0 || state_r == OWN1) && own_stb_s && !i_s_ack &&
            (cnt_r == TO_MAX)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Drive master- and slave-side outputs from the registered grant.
    always_comb begin
        o_s_cyc   = own_cyc_s;
        o_s_stb   = own_stb_s;
        o_s_we    = own_we_s;
        o_s_width = own_width_s;
        o_s_addr  = own_addr_s;
        o_s_data  = own_data_s;
        o_m0_stl  = i_m0_cyc;
        o_m1_stl  = i_m1_cyc;
        o_m0_ack  = 1'b0;
        o_m1_ack  = 1'b0;
        o_m0_err  = 1'b0;
        o_m1_err  = 1'b0;
        case (state_r)
            OWN0: begin
                o_m0_stl = i_s_stl;
                o_m0_ack = i_s_ack && !timeout_s;
                o_m0_err = timeout_s;
            end
            OWN1: begin
                o_m1_stl = i_s_stl;
                o_m1_ack = i_s_ack && !timeout_s;
                o_m1_err = timeout_s;
            end
            default: begin
                o_m0_stl = i_m0_cyc;
                o_m1_stl = i_m1_cyc;
            end
        endcase
    end

    // Read data is broadcast; masters qualify it with their own ack.
    assign o_m0_data = i_s_data;
    assign o_m1_data = i_s_data;

    // Grant state machine, round-robin flag and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
            cnt_r   <= {TO_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= {TO_W{1'b0}};
                    if (i_m0_cyc && i_m1_cyc) begin
                        if (last_r) begin
                            state_r <= OWN0;
                            last_r  <= 1'b0;
                        end else begin
                            state_r <= OWN1;
                            last_r  <= 1'b1;
                        end
                    end else if (i_m0_cyc) begin
                        state_r <= OWN0;
                        last_r  <= 1'b0;
                    end else if (i_m1_cyc) begin
                        state_r <= OWN1;
                        last_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                OWN0, OWN1: begin
                    // Grant lasts for the whole cycle; only cyc drop or timeout ends it.
                    if (!own_cyc_s || timeout_s) begin
                        state_r <= IDLE;
                        cnt_r   <= {TO_W{1'b0}};
                    end else if (i_s_ack || !own_stb_s) begin
                        cnt_r <= {TO_W{1'b0}};
                    end else if (cnt_r != TO_MAX) begin
                        cnt_r <= cnt_r + TO_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {TO_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter2
// Directed bench for wb_arbiter2 (ADDR_WIDTH=6, TIMEOUT=16). Inputs are
// driven 2 time units after the rising edge and outputs are checked one unit
// later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m1_cyc, m0_stb, m1_stb, m0_we, m1_we;
    logic [1:0]  m0_width, m1_width;
    logic [5:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_stl, m1_stl, m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_cyc, s_stb, s_we;
    logic [1:0]  s_width;
    logic [5:0]  s_addr;
    logic [31:0] s_wdata;
    logic        s_stl, s_ack;
    logic [31:0] s_rdata;

    int checks = 0;
    int errors = 0;
    int acks   = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.ADDR_WIDTH(6), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_m0_cyc(m0_cyc), .i_m1_cyc(m1_cyc),
        .i_m0_stb(m0_stb), .i_m1_stb(m1_stb),
        .i_m0_we(m0_we), .i_m1_we(m1_we),
        .i_m0_width(m0_width), .i_m1_width(m1_width),
        .i_m0_addr(m0_addr), .i_m1_addr(m1_addr),
        .i_m0_data(m0_wdata), .i_m1_data(m1_wdata),
        .o_m0_stl(m0_stl), .o_m1_stl(m1_stl),
        .o_m0_ack(m0_ack), .o_m1_ack(m1_ack),
        .o_m0_err(m0_err), .o_m1_err(m1_err),
        .o_m0_data(m0_rdata), .o_m1_data(m1_rdata),
        .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we),
        .o_s_width(s_width), .o_s_addr(s_addr), .o_s_data(s_wdata),
        .i_s_stl(s_stl), .i_s_ack(s_ack), .i_s_data(s_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_cyc = 1'b0; m1_cyc = 1'b0; m0_stb = 1'b0; m1_stb = 1'b0;
        m0_we = 1'b0; m1_we = 1'b0; m0_width = 2'b00; m1_width = 2'b00;
        m0_addr = 6'd0; m1_addr = 6'd0; m0_wdata = 32'h0; m1_wdata = 32'h0;
        s_stl = 1'b0; s_ack = 1'b0; s_rdata = 32'h0;

        // ---- reset state ----
        tick();
        settle();
        chk("rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("rst_m0_stl", 32'(m0_stl), 32'd0);
        chk("rst_m0_ack", 32'(m0_ack), 32'd0);
        rst_n = 1'b1;

        // ---- m0 single word write 0xDEADBEEF at addr 4 ----
        tick();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_width = 2'b10;
        m0_addr = 6'd4; m0_wdata = 32'hDEADBEEF;
        settle();
        chk("t1_stall", 32'(m0_stl), 32'd1);
        chk("t1_idle_s_cyc", 32'(s_cyc), 32'd0);
        tick();
        s_ack = 1'b1; s_rdata = 32'h1234_5678;
        settle();
        chk("t1_s_cyc", 32'(s_cyc), 32'd1);
        chk("t1_s_stb", 32'(s_stb), 32'd1);
        chk("t1_s_we", 32'(s_we), 32'd1);
        chk("t1_s_width", 32'(s_width), 32'd2);
        chk("t1_s_addr", 32'(s_addr), 32'd4);
        chk("t1_s_data", s_wdata, 32'hDEADBEEF);
        chk("t1_m0_ack", 32'(m0_ack), 32'd1);
        chk("t1_m0_stl", 32'(m0_stl), 32'd0);
        chk("t1_m1_stl", 32'(m1_stl), 32'd0);
        chk("t1_m1_ack", 32'(m1_ack), 32'd0);
        chk("t1_m0_rdata", m0_rdata, 32'h1234_5678);
        chk("t1_m1_rdata", m1_rdata, 32'h1234_5678);
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; s_ack = 1'b0;
        tick();
        settle();
        chk("t1_back_idle", 32'(s_cyc), 32'd0);

        // ---- simultaneous requests after reset: m0 first, then m1 ----
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 6'd8;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 6'd12;
        settle();
        chk("t2_m0_stl_idle", 32'(m0_stl), 32'd1);
        chk("t2_m1_stl_idle", 32'(m1_stl), 32'd1);
        tick();
        settle();
        chk("t2_grant_m0", 32'(s_addr), 32'd8);
        chk("t2_m0_stl", 32'(m0_stl), 32'd0);
        chk("t2_m1_stl", 32'(m1_stl), 32'd1);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();
        settle();
        chk("t2_dead_cycle", 32'(s_cyc), 32'd0);
        chk("t2_dead_m1_stl", 32'(m1_stl), 32'd1);
        tick();
        settle();
        chk("t2_grant_m1", 32'(s_addr), 32'd12);
        chk("t2_m1_stl_own", 32'(m1_stl), 32'd0);
        m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();
        m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
        settle();
        chk("t2_rr_grant_m0", 32'(s_addr), 32'd8);
        chk("t2_rr_m1_stl", 32'(m1_stl), 32'd1);
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();

        // ---- m1 holds cyc for 5 byte reads while m0 waits ----
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 6'd20;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_width = 2'b00; m1_addr = 6'd33;
        tick();
        for (int k = 0; k < 5; k++) begin
            s_ack = 1'b1; s_rdata = 32'hA0 + 32'(k);
            settle();
            chk("t3_m0_stl", 32'(m0_stl), 32'd1);
            chk("t3_m1_rdata", m1_rdata, 32'hA0 + 32'(k));
            if (m1_ack === 1'b1) acks++;
            if (k == 4) begin
                m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
            end
            tick();
        end
        chk("t3_ack_count", 32'(acks), 32'd5);
        settle();
        chk("t3_dead_cycle", 32'(s_cyc), 32'd0);
        chk("t3_dead_m0_stl", 32'(m0_stl), 32'd1);
        tick();
        settle();
        chk("t3_m0_granted", 32'(s_addr), 32'd20);
        chk("t3_m0_stl_own", 32'(m0_stl), 32'd0);

        // ---- m0 owns, slave never acks: err 16 cycles after stb ----
        for (int c = 0; c <= 16; c++) begin
            settle();
            chk($sformatf("t4_err_c%0d", c), 32'(m0_err), (c == 16) ? 32'd1 : 32'd0);
            chk($sformatf("t4_ack_c%0d", c), 32'(m0_ack), 32'd0);
            tick();
        end
        settle();
        chk("t4_err_one_cycle", 32'(m0_err), 32'd0);
        chk("t4_back_idle", 32'(s_cyc), 32'd0);
        chk("t4_idle_m0_stl", 32'(m0_stl), 32'd1);
        tick();

        // ---- ack on the cycle the counter reaches TIMEOUT wins ----
        for (int c = 0; c <= 16; c++) begin
            if (c == 16) s_ack = 1'b1;
            settle();
            chk($sformatf("t5_err_c%0d", c), 32'(m0_err), 32'd0);
            chk($sformatf("t5_ack_c%0d", c), 32'(m0_ack), (c == 16) ? 32'd1 : 32'd0);
            if (c == 16) begin
                m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
            end
            tick();
        end
        settle();
        chk("t5_back_idle", 32'(s_cyc), 32'd0);

        // ---- reset during an OWN1 transfer ----
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 6'd40;
        tick();
        settle();
        chk("t6_own1", 32'(s_addr), 32'd40);
        s_ack = 1'b1;
        rst_n = 1'b0;
        settle();
        chk("t6_rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("t6_rst_s_stb", 32'(s_stb), 32'd0);
        chk("t6_rst_s_addr", 32'(s_addr), 32'd0);
        chk("t6_rst_m1_ack", 32'(m1_ack), 32'd0);
        chk("t6_rst_m1_err", 32'(m1_err), 32'd0);
        chk("t6_rst_m1_stl", 32'(m1_stl), 32'd1);
        s_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 6'd44;
        tick();
        settle();
        chk("t6_tie_to_m0", 32'(s_addr), 32'd44);
        chk("t6_tie_m1_stl", 32'(m1_stl), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
